// File: rtl/rv_pkg.sv
// Shared constants and types for the integer register-file write-back path.
package rv_pkg;

  localparam int XLEN               = 32;
  localparam int NREG               = 32;
  localparam int REG_AW             = 5;
  localparam int STARVE_LIMIT_DFLT  = 3;

  typedef enum logic [1:0] {
    REQ_NONE,
    REQ_ALU,
    REQ_LD
  } req_id_e;

endpackage

// File: rtl/wb_scoreboard.sv
// Pending-write scoreboard: one bit per architectural register, x0 never pending.
// Drives the combinational RAW/WAW stall seen by the issue stage.
module wb_scoreboard
  import rv_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              issue_valid,
  input  logic [REG_AW-1:0] issue_rd,
  input  logic              issue_wr,
  input  logic [REG_AW-1:0] rs1_addr,
  input  logic [REG_AW-1:0] rs2_addr,
  input  logic              clr_en,
  input  logic [REG_AW-1:0] clr_addr,
  output logic              issue_stall,
  output logic [NREG-1:0]   pending
);

  logic [NREG-1:0] r_pending;
  logic [NREG-1:0] w_pending_next;
  logic            w_set;

  assign issue_stall = issue_valid & (r_pending[rs1_addr] | r_pending[rs2_addr] |
                                      (issue_wr & r_pending[issue_rd]));

  assign w_set = issue_valid & issue_wr & ~issue_stall & (issue_rd != '0);

  // Set is applied after clear so a same-edge set/clear on one bit leaves it set.
  always_comb begin
    w_pending_next = r_pending;
    if (clr_en) begin
      w_pending_next[clr_addr] = 1'b0;
    end
    if (w_set) begin
      w_pending_next[issue_rd] = 1'b1;
    end
    w_pending_next[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_pending <= '0;
    end else begin
      r_pending <= w_pending_next;
    end
  end

  assign pending = r_pending;

endmodule

// File: rtl/regfile_wb_ctrl.sv
// Write-back controller: arbitrates the register file's single write port between
// the ALU and load paths, with an ALU anti-starvation override and a pending scoreboard.
module regfile_wb_ctrl
  import rv_pkg::*;
#(
  parameter int STARVE_LIMIT = STARVE_LIMIT_DFLT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              alu_valid,
  input  logic [REG_AW-1:0] alu_rd,
  input  logic [XLEN-1:0]   alu_data,
  output logic              alu_ready,
  input  logic              ld_valid,
  input  logic [REG_AW-1:0] ld_rd,
  input  logic [XLEN-1:0]   ld_data,
  output logic              ld_ready,
  input  logic              issue_valid,
  input  logic [REG_AW-1:0] issue_rd,
  input  logic              issue_wr,
  input  logic [REG_AW-1:0] rs1_addr,
  input  logic [REG_AW-1:0] rs2_addr,
  output logic              issue_stall,
  output logic              wb_wen,
  output logic [REG_AW-1:0] wb_addr,
  output logic [XLEN-1:0]   wb_data
);

  localparam logic [1:0] LIMIT = 2'(STARVE_LIMIT);

  req_id_e           w_grant;
  logic [REG_AW-1:0] w_sel_rd;
  logic [XLEN-1:0]   w_sel_data;
  logic [1:0]        r_starve_cnt;
  logic              r_wb_wen;
  logic [REG_AW-1:0] r_wb_addr;
  logic [XLEN-1:0]   r_wb_data;
  logic [NREG-1:0]   w_pending;

  // Load wins by default; a starved ALU overrides it once the counter saturates.
  always_comb begin
    w_grant = REQ_NONE;
    if (rst) begin
      if (alu_valid && (!ld_valid || r_starve_cnt == LIMIT)) begin
        w_grant = REQ_ALU;
      end else if (ld_valid) begin
        w_grant = REQ_LD;
      end
    end
  end

  assign alu_ready  = (w_grant == REQ_ALU);
  assign ld_ready   = (w_grant == REQ_LD);
  assign w_sel_rd   = (w_grant == REQ_ALU) ? alu_rd   : ld_rd;
  assign w_sel_data = (w_grant == REQ_ALU) ? alu_data : ld_data;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_starve_cnt <= '0;
    end else if (!alu_valid || w_grant == REQ_ALU) begin
      r_starve_cnt <= '0;
    end else if (r_starve_cnt != LIMIT) begin
      r_starve_cnt <= r_starve_cnt + 2'd1;
    end
  end

  // A grant to x0 completes the handshake but never raises the write enable.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wb_wen  <= 1'b0;
      r_wb_addr <= '0;
      r_wb_data <= '0;
    end else if (w_grant != REQ_NONE) begin
      r_wb_wen  <= (w_sel_rd != '0);
      r_wb_addr <= w_sel_rd;
      r_wb_data <= w_sel_data;
    end else begin
      r_wb_wen  <= 1'b0;
    end
  end

  assign wb_wen  = r_wb_wen;
  assign wb_addr = r_wb_addr;
  assign wb_data = r_wb_data;

  wb_scoreboard u_sb (
    .clk         (clk),
    .rst         (rst),
    .issue_valid (issue_valid),
    .issue_rd    (issue_rd),
    .issue_wr    (issue_wr),
    .rs1_addr    (rs1_addr),
    .rs2_addr    (rs2_addr),
    .clr_en      (r_wb_wen),
    .clr_addr    (r_wb_addr),
    .issue_stall (issue_stall),
    .pending     (w_pending)
  );

endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// Self-checking bench for regfile_wb_ctrl: expected writes are queued at stimulus time
// and popped when the register-file write port fires.
module tb_regfile_wb_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        alu_valid, ld_valid, alu_ready, ld_ready;
  logic [4:0]  alu_rd, ld_rd;
  logic [31:0] alu_data, ld_data;
  logic        issue_valid, issue_wr, issue_stall;
  logic [4:0]  issue_rd, rs1_addr, rs2_addr;
  logic        wb_wen;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;

  typedef struct {
    logic [4:0]  a;
    logic [31:0] d;
  } wr_t;

  wr_t         exp_q[$];
  logic [31:0] rf[32];
  int          n_asserts = 0;
  int          n_fail    = 0;

  always #5 clk = ~clk;

  regfile_wb_ctrl dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
    .ld_valid(ld_valid), .ld_rd(ld_rd), .ld_data(ld_data), .ld_ready(ld_ready),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_wr(issue_wr),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .issue_stall(issue_stall),
    .wb_wen(wb_wen), .wb_addr(wb_addr), .wb_data(wb_data)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_asserts++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end else begin
      $display("ok   %s: %h", tag, act);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_wr(input logic [4:0] a, input logic [31:0] d);
    wr_t e;
    e.a = a;
    e.d = d;
    exp_q.push_back(e);
  endtask

  // Register-file write port model plus scoreboard pop, sampled on the negedge.
  always @(negedge clk) begin
    wr_t e;
    if (wb_wen) begin
      rf[wb_addr] = wb_data;
      if (exp_q.size() == 0) begin
        check("wb_unexpected", exp_q.size(), 1);
      end else begin
        e = exp_q.pop_front();
        check("wb_addr", {27'b0, wb_addr}, {27'b0, e.a});
        check("wb_data", wb_data, e.d);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  li;
    bit  alu_pend;
    rst = 1'b0;
    alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 32'h1;
    ld_valid = 1'b1;  ld_rd = 5'd2;  ld_data = 32'h2;
    issue_valid = 1'b0; issue_wr = 1'b0; issue_rd = '0; rs1_addr = '0; rs2_addr = '0;
    for (int i = 0; i < 32; i++) rf[i] = '0;

    // Reset state
    repeat (3) step();
    check("rst_alu_ready", alu_ready, 0);
    check("rst_ld_ready", ld_ready, 0);
    check("rst_wb_wen", wb_wen, 0);
    check("rst_wb_addr", wb_addr, 0);
    check("rst_wb_data", wb_data, 0);
    check("rst_pending", dut.u_sb.r_pending, 0);
    alu_valid = 1'b0; ld_valid = 1'b0;
    rst = 1'b1;
    step();

    // Single ALU write
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
    #1;
    check("single_alu_ready", alu_ready, 1);
    check("single_ld_ready", ld_ready, 0);
    push_wr(5'd5, 32'hDEADBEEF);
    step();
    alu_valid = 1'b0;
    check("single_wen_n1", wb_wen, 1);
    step();
    check("single_rf5", rf[5], 32'hDEADBEEF);
    check("single_wen_drop", wb_wen, 0);
    check("single_addr_hold", wb_addr, 5);

    // Contention: ld rd 1..8 continuously, one ALU request to rd 9
    push_wr(5'd1, 32'h101); push_wr(5'd2, 32'h102); push_wr(5'd3, 32'h103);
    push_wr(5'd9, 32'hA9);
    for (int k = 4; k <= 8; k++) push_wr(5'(k), 32'h100 + 32'(k));
    li = 1;
    alu_pend = 1'b1;
    for (int c = 0; c < 30 && (li <= 8 || alu_pend); c++) begin
      ld_valid  = (li <= 8);
      ld_rd     = 5'(li);
      ld_data   = 32'h100 + 32'(li);
      alu_valid = alu_pend;
      alu_rd    = 5'd9;
      alu_data  = 32'hA9;
      #1;
      if (c < 9) begin
        check($sformatf("cont_alu_ready_c%0d", c), alu_ready, (c == 3));
        check($sformatf("cont_ld_ready_c%0d", c), ld_ready, (c != 3));
      end
      if (c == 3) check("cont_starve_cnt", dut.r_starve_cnt, 3);
      if (ld_ready) li++;
      if (alu_ready) alu_pend = 1'b0;
      step();
    end
    ld_valid = 1'b0; alu_valid = 1'b0;
    repeat (3) step();
    check("cont_queue_drained", exp_q.size(), 0);

    // Scoreboard RAW on rd 7
    issue_valid = 1'b1; issue_wr = 1'b1; issue_rd = 5'd7; rs1_addr = '0; rs2_addr = '0;
    #1;
    check("raw_issue_nostall", issue_stall, 0);
    step();
    issue_wr = 1'b0; issue_rd = '0; rs1_addr = 5'd7;
    check("raw_pending7", dut.u_sb.r_pending[7], 1);
    check("raw_stall_rs1", issue_stall, 1);
    alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 32'h77;
    push_wr(5'd7, 32'h77);
    #1;
    check("raw_stall_grant", issue_stall, 1);
    step();
    alu_valid = 1'b0;
    check("raw_stall_wen", issue_stall, 1);
    step();
    check("raw_unstall", issue_stall, 0);
    check("raw_rf7", rf[7], 32'h77);

    // WAW on rd 10: rd lookup stalls only when the instruction writes
    rs1_addr = '0; issue_wr = 1'b1; issue_rd = 5'd10;
    step();
    rs2_addr = 5'd10; issue_wr = 1'b0; issue_rd = '0;
    #1;
    check("rs2_stall", issue_stall, 1);
    rs2_addr = '0; issue_rd = 5'd10;
    #1;
    check("waw_nowr_nostall", issue_stall, 0);
    issue_wr = 1'b1;
    #1;
    check("waw_stall", issue_stall, 1);
    issue_valid = 1'b0; issue_wr = 1'b0;
    #1;
    check("stall_needs_valid", issue_stall, 0);
    alu_valid = 1'b1; alu_rd = 5'd10; alu_data = 32'hA0;
    push_wr(5'd10, 32'hA0);
    step();
    alu_valid = 1'b0;
    step();

    // Simultaneous set/clear on rd 3
    alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'h33;
    push_wr(5'd3, 32'h33);
    step();
    alu_valid = 1'b0;
    issue_valid = 1'b1; issue_wr = 1'b1; issue_rd = 5'd3;
    #1;
    check("setclr_wen", wb_wen, 1);
    check("setclr_nostall", issue_stall, 0);
    step();
    issue_valid = 1'b0; issue_wr = 1'b0;
    check("setclr_pending3", dut.u_sb.r_pending[3], 1);
    alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'h3333;
    push_wr(5'd3, 32'h3333);
    step();
    alu_valid = 1'b0;
    step();
    check("setclr_cleared", dut.u_sb.r_pending, 0);

    // x0: accepted but never written, never pending
    alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'h1234;
    #1;
    check("x0_alu_ready", alu_ready, 1);
    step();
    alu_valid = 1'b0;
    check("x0_wen", wb_wen, 0);
    issue_valid = 1'b1; issue_wr = 1'b1; issue_rd = 5'd0;
    #1;
    check("x0_issue_nostall", issue_stall, 0);
    step();
    check("x0_pending", dut.u_sb.r_pending, 0);

    // Reset mid-stream with pending = 0xF0
    for (int k = 4; k < 8; k++) begin
      issue_rd = 5'(k);
      step();
    end
    issue_valid = 1'b0; issue_wr = 1'b0; issue_rd = '0;
    check("mid_pending_f0", dut.u_sb.r_pending, 32'h000000F0);
    alu_valid = 1'b1; alu_rd = 5'd20; alu_data = 32'h20;
    ld_valid  = 1'b1; ld_rd  = 5'd21; ld_data  = 32'h21;
    #1;
    check("mid_ld_ready", ld_ready, 1);
    push_wr(5'd21, 32'h21);
    step();
    check("mid_wen_before", wb_wen, 1);
    check("mid_starve_before", dut.r_starve_cnt, 1);
    rst = 1'b0;
    #1;
    check("mid_rst_alu_ready", alu_ready, 0);
    check("mid_rst_ld_ready", ld_ready, 0);
    step();
    check("mid_rst_wen", wb_wen, 0);
    check("mid_rst_pending", dut.u_sb.r_pending, 0);
    check("mid_rst_starve", dut.r_starve_cnt, 0);
    alu_valid = 1'b0; ld_valid = 1'b0;
    rst = 1'b1;
    repeat (3) step();
    check("final_queue_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
